pilsner_spawn_scheduler: RTL and testbench

Game-level scheduler for the Pilsner falling-bottle game. It owns LANES bottle lanes, each driven by one bottle instance. It decides when and in which lane the next bottle drops, caps how many bottles fall at once, and keeps score, lives and game-over state from per-lane caught/missed events. It sits between the per-lane bottle objects and the game top-level.

---
 rtl/pilsner_spawn_scheduler.sv | 171 +++++++++++++++++
 tb/tb_pilsner_spawn_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pilsner_spawn_scheduler.sv
// Pilsner game scheduler: paces bottle launches into free lanes and keeps
// score, lives and game-over state from the per-lane caught/missed events.
module pilsner_spawn_scheduler #(
  parameter int         LANES       = 4,
  parameter int         SPAWN_DELAY = 50_000_000,
  parameter int         MAX_ACTIVE  = 2,
  parameter int         LIVES_INIT  = 3,
  parameter logic [7:0] SEED        = 8'hA5,
  parameter int         SCORE_W     = 10
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               pause_i,
  input  logic               start_i,
  input  logic [LANES-1:0]   caught_i,
  input  logic [LANES-1:0]   missed_i,
  output logic [LANES-1:0]   launch_o,
  output logic [LANES-1:0]   active_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [2:0]         lives_o,
  output logic               game_over_o
);

  localparam int GAP_W = $clog2(SPAWN_DELAY);
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SPAWN_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PICK,
    S_LAUNCH,
    S_OVER
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic [3:0]         tried_q, tried_d;
  logic [LANES-1:0]   launch_q, launch_d;
  logic [LANES-1:0]   active_q, active_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic               over_q, over_d;

  logic [LANES-1:0]   validCaught, validMissed;
  logic [3:0]         nCaught, nMissed;
  logic [SCORE_W:0]   scoreSum;
  logic               playing;

  function automatic logic [3:0] popcnt(input logic [LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      lfsr_q   <= SEED;
      scan_q   <= '0;
      tried_q  <= '0;
      launch_q <= '0;
      active_q <= '0;
      score_q  <= '0;
      lives_q  <= 3'(LIVES_INIT);
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      lfsr_q   <= lfsr_d;
      scan_q   <= scan_d;
      tried_q  <= tried_d;
      launch_q <= launch_d;
      active_q <= active_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      over_q   <= over_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    lfsr_d   = lfsr_q;
    scan_d   = scan_q;
    tried_d  = tried_q;
    launch_d = '0;
    active_d = active_q;
    score_d  = score_q;
    lives_d  = lives_q;
    over_d   = over_q;

    // Events only count against lanes already falling; caught beats missed.
    validCaught = caught_i & active_q;
    validMissed = missed_i & active_q & ~caught_i;
    nCaught     = popcnt(validCaught);
    nMissed     = popcnt(validMissed);
    scoreSum    = {1'b0, score_q} + (SCORE_W + 1)'(nCaught);
    playing     = (state_q == S_WAIT) || (state_q == S_PICK) || (state_q == S_LAUNCH);

    if (!pause_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    if (!pause_i) begin
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_i) begin
            state_d  = S_WAIT;
            gap_d    = '0;
            score_d  = '0;
            lives_d  = 3'(LIVES_INIT);
            over_d   = 1'b0;
            active_d = '0;
          end
        end
        S_WAIT: begin
          if (gap_q == GAP_MAX && popcnt(active_q) < 4'(MAX_ACTIVE)) begin
            state_d = S_PICK;
            scan_d  = IDX_W'({1'b0, lfsr_q[2:0]} % 4'(LANES));
            tried_d = '0;
          end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_PICK: begin
          if (!active_q[scan_q]) begin
            state_d          = S_LAUNCH;
            launch_d[scan_q] = 1'b1;
          end else begin
            scan_d  = (scan_q == IDX_MAX) ? '0 : scan_q + 1'b1;
            tried_d = tried_q + 4'd1;
            if (tried_q == 4'(LANES - 1)) state_d = S_WAIT;
          end
        end
        S_LAUNCH: begin
          state_d = S_WAIT;
          gap_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Running out of lives wins over any launch decided on the same edge.
    if (playing) begin
      active_d = (active_q & ~(validCaught | validMissed)) | launch_d;
      score_d  = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
      if (nMissed != 4'd0 && nMissed >= {1'b0, lives_q}) begin
        lives_d  = '0;
        state_d  = S_OVER;
        over_d   = 1'b1;
        active_d = '0;
        launch_d = '0;
      end else begin
        lives_d = lives_q - nMissed[2:0];
      end
    end
  end

  assign launch_o    = launch_q;
  assign active_o    = active_q;
  assign score_o     = score_q;
  assign lives_o     = lives_q;
  assign game_over_o = over_q;

endmodule

// File: tb/tb_pilsner_spawn_scheduler.sv
// Bench for pilsner_spawn_scheduler: directed game scenarios checked every cycle
// against a lane/score/lives model, plus hand-computed timing and value pins.
module tb_pilsner_spawn_scheduler;

  localparam int         LANES       = 4;
  localparam int         SPAWN_DELAY = 4;
  localparam int         MAX_ACTIVE  = 2;
  localparam int         LIVES_INIT  = 3;
  localparam logic [7:0] SEED        = 8'hA5;
  localparam int         SCORE_W     = 10;
  localparam int         SCORE_MAX   = (1 << SCORE_W) - 1;

  logic               clk_i = 1'b0;
  logic               reset_i, pause_i, start_i;
  logic [LANES-1:0]   caught_i, missed_i;
  logic [LANES-1:0]   launch_o, active_o;
  logic [SCORE_W-1:0] score_o;
  logic [2:0]         lives_o;
  logic               game_over_o;

  always #5 clk_i = ~clk_i;

  pilsner_spawn_scheduler #(
    .LANES(LANES), .SPAWN_DELAY(SPAWN_DELAY), .MAX_ACTIVE(MAX_ACTIVE),
    .LIVES_INIT(LIVES_INIT), .SEED(SEED), .SCORE_W(SCORE_W)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pause_i(pause_i), .start_i(start_i),
    .caught_i(caught_i), .missed_i(missed_i), .launch_o(launch_o),
    .active_o(active_o), .score_o(score_o), .lives_o(lives_o),
    .game_over_o(game_over_o)
  );

  int nVec = 0;
  int nBad = 0;
  bit cmpEn = 1'b0;

  // Model of the game as the rules describe it: who is falling, how far the
  // spawn gap has run, and an in-progress lane scan.
  bit         mPlaying, mOver, mInLaunch;
  int         mGap, mScanLeft, mScanPos, mScore, mLives;
  logic [7:0] mLfsr;
  logic [3:0] mActive, mLaunch;

  function automatic int countOnes(input logic [3:0] v);
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic logic [3:0] lowestBit(input logic [3:0] v);
    logic [3:0] r = 4'b0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 4'b0001 << i;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual != expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    nVec++;
    nBad++;
    $display("[TB] FAIL %s: condition not reached within cycle budget (t=%0t)", name, $time);
  endtask

  always @(posedge clk_i) begin : refModel
    logic [3:0] ev, ms, keep, fresh;
    int lost;
    if (reset_i) begin
      mPlaying = 0; mOver = 0; mInLaunch = 0;
      mGap = 0; mScanLeft = 0; mScanPos = 0;
      mScore = 0; mLives = LIVES_INIT;
      mActive = 0; mLaunch = 0; mLfsr = SEED;
    end else begin
      fresh = 4'b0;
      if (mPlaying) begin
        ev   = caught_i & mActive;
        ms   = missed_i & mActive & ~caught_i;
        keep = mActive & ~(ev | ms);
        mScore = mScore + countOnes(ev);
        if (mScore > SCORE_MAX) mScore = SCORE_MAX;
        lost = countOnes(ms);
        if (!pause_i) begin
          if (mInLaunch) begin
            mInLaunch = 0;
            mGap = 0;
          end else if (mScanLeft > 0) begin
            if (((mActive >> mScanPos) & 4'd1) == 4'd0) begin
              fresh = 4'b0001 << mScanPos;
              mInLaunch = 1;
              mScanLeft = 0;
            end else begin
              mScanPos = (mScanPos + 1) % LANES;
              mScanLeft--;
            end
          end else if (mGap == SPAWN_DELAY - 1 && countOnes(mActive) < MAX_ACTIVE) begin
            mScanLeft = LANES;
            mScanPos  = int'(mLfsr[2:0]) % LANES;
          end else if (mGap < SPAWN_DELAY - 1) begin
            mGap++;
          end
        end
        if (lost > 0 && lost >= mLives) begin
          mLives = 0; mPlaying = 0; mOver = 1;
          mInLaunch = 0; mScanLeft = 0;
          mActive = 0; mLaunch = 0;
        end else begin
          mLives  = mLives - lost;
          mActive = keep | fresh;
          mLaunch = fresh;
        end
      end else begin
        mLaunch = 0;
        if (!pause_i && start_i) begin
          mPlaying = 1; mOver = 0; mInLaunch = 0;
          mGap = 0; mScanLeft = 0;
          mScore = 0; mLives = LIVES_INIT; mActive = 0;
        end
      end
      if (!pause_i) mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
    end
  end

  always @(negedge clk_i) begin
    if (cmpEn) begin
      checkOutput("launch", int'(launch_o), int'(mLaunch));
      checkOutput("active", int'(active_o), int'(mActive));
      checkOutput("score", int'(score_o), mScore);
      checkOutput("lives", int'(lives_o), mLives);
      checkOutput("game_over", int'(game_over_o), int'(mOver));
    end
  end

  task automatic applyStimulus(input bit r, input bit p, input bit s,
                               input logic [3:0] c, input logic [3:0] m);
    reset_i  = r;
    pause_i  = p;
    start_i  = s;
    caught_i = c;
    missed_i = m;
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'b0, 4'b0);
  endtask

  task automatic measureLaunch(input int budget, output int n);
    n = 0;
    while (launch_o == 4'b0 && n < budget) begin
      applyStimulus(0, 0, 0, 4'b0, 4'b0);
      n++;
    end
  endtask

  task automatic waitModelActive(input int want, input int budget);
    int n = 0;
    while (countOnes(mActive) != want && n < budget) begin
      applyStimulus(0, 0, 0, 4'b0, 4'b0);
      n++;
    end
    if (countOnes(mActive) != want) timeoutFail("wait for active lanes");
  endtask

  initial begin : stimulus
    int n, tally;
    logic [3:0] lane;

    applyStimulus(1, 0, 0, 4'b0, 4'b0);
    cmpEn = 1'b1;
    applyStimulus(1, 0, 0, 4'b0, 4'b0);
    checkOutput("reset score", int'(score_o), 0);
    checkOutput("reset lives", int'(lives_o), 3);
    checkOutput("reset active", int'(active_o), 0);
    checkOutput("reset launch", int'(launch_o), 0);
    checkOutput("reset game_over", int'(game_over_o), 0);
    idle(3);

    // First launch lands 5 cycles after WAIT entry, second 6+k later, no third.
    applyStimulus(0, 0, 1, 4'b0, 4'b0);
    measureLaunch(12, n);
    checkOutput("first launch delay", n, 5);
    checkOutput("first launch one-hot", countOnes(launch_o), 1);
    checkOutput("first launch lane active", countOnes(active_o & launch_o), 1);
    idle(1);
    checkOutput("launch pulse width", int'(launch_o), 0);
    measureLaunch(20, n);
    checkOutput("second launch spacing 6..7", int'((n + 1) >= 6 && (n + 1) <= 7), 1);
    tally = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, (i == 7), 4'b0, 4'b0);
      tally += countOnes(launch_o);
    end
    checkOutput("no third launch", tally, 0);
    checkOutput("two lanes active", countOnes(active_o), 2);

    // Freeing one lane of a full board refills within 2+k cycles.
    lane = lowestBit(mActive);
    applyStimulus(0, 0, 0, lane, 4'b0);
    checkOutput("stall catch score", int'(score_o), 1);
    checkOutput("stall catch frees lane", countOnes(active_o), 1);
    measureLaunch(10, n);
    checkOutput("refill within 2+k", int'(n >= 2 && n <= 3), 1);
    idle(6);

    for (int i = 0; i < 3; i++) begin
      lane = lowestBit(mActive);
      applyStimulus(0, 0, 0, 4'b0, lane);
      checkOutput("lives after miss", int'(lives_o), 2 - i);
      if (i < 2) begin
        waitModelActive(2, 20);
        idle(5);
      end
    end
    checkOutput("game over flag", int'(game_over_o), 1);
    checkOutput("game over clears active", int'(active_o), 0);
    tally = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 0, 0, 4'b1111, 4'b1111);
      tally += countOnes(launch_o);
    end
    checkOutput("no launch while over", tally, 0);
    applyStimulus(0, 0, 1, 4'b0, 4'b0);
    checkOutput("restart lives", int'(lives_o), 3);
    checkOutput("restart score", int'(score_o), 0);
    checkOutput("restart game_over", int'(game_over_o), 0);

    // Same-cycle caught+missed, an event on an idle lane, and a double catch.
    waitModelActive(2, 30);
    lane = lowestBit(mActive);
    applyStimulus(0, 0, 0, lane, lane);
    checkOutput("caught wins score", int'(score_o), 1);
    checkOutput("caught wins lives", int'(lives_o), 3);
    lane = lowestBit(~mActive);
    applyStimulus(0, 0, 0, 4'b0, lane);
    checkOutput("idle lane miss ignored", int'(lives_o), 3);
    waitModelActive(2, 30);
    applyStimulus(0, 0, 0, mActive, 4'b0);
    checkOutput("double catch score", int'(score_o), 3);
    checkOutput("double catch frees both", int'(active_o), 0);

    // Pause two cycles into a gap; the remaining gap resumes on release.
    n = 0;
    while (mLaunch == 4'b0 && n < 20) begin
      idle(1);
      n++;
    end
    if (mLaunch == 4'b0) timeoutFail("wait for launch before pause");
    idle(2);
    tally = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0, (i == 5) ? mActive : 4'b0, 4'b0);
      tally += countOnes(launch_o);
    end
    checkOutput("no launch while paused", tally, 0);
    checkOutput("catch during pause score", int'(score_o), 4);
    measureLaunch(12, n);
    checkOutput("launch after remaining gap", n, 4);

    // Reset on the edge that would have entered LAUNCH.
    n = 0;
    while (!(mPlaying && !mInLaunch && mScanLeft > 0 &&
             ((mActive >> mScanPos) & 4'd1) == 4'd0) && n < 20) begin
      idle(1);
      n++;
    end
    if (n >= 20) timeoutFail("wait for launch decision");
    applyStimulus(1, 0, 0, 4'b0, 4'b0);
    checkOutput("reset kills launch", int'(launch_o), 0);
    checkOutput("reset mid-game active", int'(active_o), 0);
    checkOutput("reset mid-game score", int'(score_o), 0);
    checkOutput("reset mid-game lives", int'(lives_o), 3);
    checkOutput("reset mid-game game_over", int'(game_over_o), 0);
    tally = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 4'b0, 4'b0);
      tally += countOnes(launch_o);
    end
    checkOutput("idle after reset no launch", tally, 0);

    cmpEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
